// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_ctrl_if                                                 |
// | M-stage request inputs and memory bus of the load/store controller |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface mem_access_ctrl_if;
   logic [31:0] IR_M;
   logic [31:0] addr_M;
   logic [31:0] wdata_M;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        stall;
   logic [31:0] ld_data;
   logic        ld_valid;
   logic        adel;
   logic        ades;
   logic        bus_err;

   modport master (
      input  IR_M, addr_M, wdata_M, mem_rdata, mem_ready,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             stall, ld_data, ld_valid, adel, ades, bus_err
   );

   modport slave (
      output IR_M, addr_M, wdata_M, mem_rdata, mem_ready,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             stall, ld_data, ld_valid, adel, ades, bus_err
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_ctrl                                                    |
// | M-stage load/store sequencer: one request at a time, with timeout  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module mem_access_ctrl #(
   parameter int TIMEOUT = 255
) (
   input wire                 clk,
   input wire                 reset,
   mem_access_ctrl_if.master  bus
);
   localparam logic [5:0] c_OP_LW  = 6'b100011;
   localparam logic [5:0] c_OP_LB  = 6'b100000;
   localparam logic [5:0] c_OP_LBU = 6'b100100;
   localparam logic [5:0] c_OP_LH  = 6'b100001;
   localparam logic [5:0] c_OP_LHU = 6'b100101;
   localparam logic [5:0] c_OP_SW  = 6'b101011;
   localparam logic [5:0] c_OP_SB  = 6'b101000;
   localparam logic [5:0] c_OP_SH  = 6'b101001;
   localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [7:0]  r_wait;
   logic [5:0]  r_op;
   logic [1:0]  r_off;
   logic [29:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic        r_we;
   logic [31:0] r_ld_data;
   logic        r_bus_err;

   logic [5:0]  w_op;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_misal;
   logic        w_accept;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ld_ext;
   logic        w_unused;

   assign w_op       = bus.IR_M[31:26];
   assign w_unused   = &{1'b0, bus.IR_M[25:0]};
   assign w_is_load  = (w_op == c_OP_LW) || (w_op == c_OP_LB) || (w_op == c_OP_LBU) ||
                       (w_op == c_OP_LH) || (w_op == c_OP_LHU);
   assign w_is_store = (w_op == c_OP_SW) || (w_op == c_OP_SB) || (w_op == c_OP_SH);

   always_comb begin
      w_misal = 1'b0;
      if (w_op == c_OP_LW || w_op == c_OP_SW)
         w_misal = |bus.addr_M[1:0];
      else if (w_op == c_OP_LH || w_op == c_OP_LHU || w_op == c_OP_SH)
         w_misal = bus.addr_M[0];
   end

   assign w_accept = (r_state == IDLE) && (w_is_load || w_is_store) && !w_misal;

   // Loads fall through to the full-word defaults.
   always_comb begin
      w_st_be    = 4'b1111;
      w_st_wdata = bus.wdata_M;
      case (w_op)
         c_OP_SB: begin
            w_st_be    = 4'b0001 << bus.addr_M[1:0];
            w_st_wdata = {4{bus.wdata_M[7:0]}};
         end
         c_OP_SH: begin
            w_st_be    = bus.addr_M[1] ? 4'b1100 : 4'b0011;
            w_st_wdata = {2{bus.wdata_M[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_byte = 8'(bus.mem_rdata >> {r_off, 3'b000});
      w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (r_op)
         c_OP_LB:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
         c_OP_LBU: w_ld_ext = {24'h0, w_byte};
         c_OP_LH:  w_ld_ext = {{16{w_half[15]}}, w_half};
         c_OP_LHU: w_ld_ext = {16'h0, w_half};
         default:  w_ld_ext = bus.mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_wait    <= 8'd0;
         r_op      <= 6'd0;
         r_off     <= 2'd0;
         r_addr    <= 30'd0;
         r_be      <= 4'd0;
         r_wdata   <= 32'd0;
         r_we      <= 1'b0;
         r_ld_data <= 32'd0;
         r_bus_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op    <= w_op;
                  r_off   <= bus.addr_M[1:0];
                  r_addr  <= bus.addr_M[31:2];
                  r_be    <= w_st_be;
                  r_wdata <= w_st_wdata;
                  r_we    <= w_is_store;
                  r_wait  <= 8'd0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               // A response in the final allowed cycle still wins over the timeout.
               if (bus.mem_ready) begin
                  if (!r_we)
                     r_ld_data <= w_ld_ext;
                  r_state <= DONE;
               end else if (r_wait == c_TMO_LAST) begin
                  r_bus_err <= 1'b1;
                  r_ld_data <= 32'd0;
                  r_state   <= DONE;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            DONE: begin
               r_bus_err <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mem_req   = (r_state == BUSY);
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = {r_addr, 2'b00};
   assign bus.mem_be    = r_be;
   assign bus.mem_wdata = r_wdata;
   assign bus.stall     = w_accept || (r_state == BUSY);
   assign bus.ld_data   = r_ld_data;
   assign bus.ld_valid  = (r_state == DONE) && !r_we;
   assign bus.bus_err   = r_bus_err;
   assign bus.adel      = (r_state == IDLE) && w_is_load && w_misal;
   assign bus.ades      = (r_state == IDLE) && w_is_store && w_misal;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access_ctrl                                                 |
// | Directed vector table plus reset / back-to-back sequences          |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_mem_access_ctrl;
   localparam logic [5:0] c_LW  = 6'b100011;
   localparam logic [5:0] c_LB  = 6'b100000;
   localparam logic [5:0] c_LBU = 6'b100100;
   localparam logic [5:0] c_LH  = 6'b100001;
   localparam logic [5:0] c_LHU = 6'b100101;
   localparam logic [5:0] c_SW  = 6'b101011;
   localparam logic [5:0] c_SB  = 6'b101000;
   localparam logic [5:0] c_SH  = 6'b101001;
   localparam logic [5:0] c_ADD = 6'b000000;
   localparam logic [5:0] c_LWL = 6'b100010;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      logic [3:0]  x_be;
      logic        x_we;
      logic [31:0] x_wdata;
      logic [31:0] x_ld_data;
      logic        x_adel;
      logic        x_ades;
      int          x_busy;
      logic        x_berr;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t vecs[$];

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr, wdata, rdata,
                               input int delay, input logic [3:0] be, input logic we,
                               input logic [31:0] xwd, xld, input logic adel, ades,
                               input int busy, input logic berr);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.delay = delay;
      v.x_be = be; v.x_we = we; v.x_wdata = xwd; v.x_ld_data = xld;
      v.x_adel = adel; v.x_ades = ades; v.x_busy = busy; v.x_berr = berr;
      return v;
   endfunction

   task automatic nop();
      bus.IR_M = {c_ADD, 26'h0};
      bus.mem_ready = 1'b0;
   endtask

   // Called just after a rising edge; returns just after a rising edge with a nop driven.
   task automatic run_vec(input int i, input vec_t v);
      int busy_n;
      string t;
      t = $sformatf("v%0d", i);
      bus.IR_M = {v.op, 26'h0}; bus.addr_M = v.addr; bus.wdata_M = v.wdata;
      bus.mem_rdata = v.rdata; bus.mem_ready = 1'b0;
      @(negedge clk);
      chk({t, " adel"}, bus.adel, v.x_adel);
      chk({t, " ades"}, bus.ades, v.x_ades);
      chk({t, " stall_c0"}, bus.stall, v.x_busy != 0);
      chk({t, " req_c0"}, bus.mem_req, 0);
      if (v.x_busy == 0) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk({t, " req_idle"}, bus.mem_req, 0);
         chk({t, " stall_idle"}, bus.stall, 0);
         @(posedge clk); #1;
         nop();
         return;
      end
      busy_n = 0;
      forever begin
         @(posedge clk); #1;
         bus.mem_ready = (busy_n == v.delay);
         @(negedge clk);
         if (!bus.mem_req) break;
         chk({t, " be"}, bus.mem_be, v.x_be);
         chk({t, " addr"}, bus.mem_addr, {v.addr[31:2], 2'b00});
         chk({t, " we"}, bus.mem_we, v.x_we);
         if (v.x_we) chk({t, " wdata"}, bus.mem_wdata, v.x_wdata);
         busy_n++;
         if (busy_n > 20) begin
            chk({t, " busy_bound"}, 1, 0);
            break;
         end
      end
      chk({t, " busy_cycles"}, busy_n, v.x_busy);
      chk({t, " stall_done"}, bus.stall, 0);
      chk({t, " ld_valid"}, bus.ld_valid, !v.x_we);
      chk({t, " bus_err"}, bus.bus_err, v.x_berr);
      if (!v.x_we) chk({t, " ld_data"}, bus.ld_data, v.x_ld_data);
      @(posedge clk); #1;
      nop();
      @(negedge clk);
      chk({t, " ld_valid_after"}, bus.ld_valid, 0);
      chk({t, " bus_err_after"}, bus.bus_err, 0);
      chk({t, " req_after"}, bus.mem_req, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] ops [3];
      logic [0:6]  e_req, e_stall, e_lv;
      int          idx;
      logic        stl;

      //             op     addr       wdata         rdata         dly be      we    xwdata        xld           adel  ades  busy berr
      vecs.push_back(mk(c_LB,  32'h1003, 32'h0,        32'h80FF_1234, 0, 4'hF, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 1, 1'b0));
      vecs.push_back(mk(c_SH,  32'h2002, 32'h0000_BEEF, 32'h0,        0, 4'hC, 1'b1, 32'hBEEF_BEEF, 32'h0,        1'b0, 1'b0, 1, 1'b0));
      vecs.push_back(mk(c_LW,  32'h3001, 32'h0,        32'h0,         0, 4'h0, 1'b0, 32'h0,        32'h0,         1'b1, 1'b0, 0, 1'b0));
      vecs.push_back(mk(c_LHU, 32'h0040, 32'h0,        32'h1234_5678, 99, 4'hF, 1'b0, 32'h0,       32'h0,         1'b0, 1'b0, 4, 1'b1));
      vecs.push_back(mk(c_LBU, 32'h1001, 32'h0,        32'h80FF_1234, 2, 4'hF, 1'b0, 32'h0,        32'h0000_0012, 1'b0, 1'b0, 3, 1'b0));
      vecs.push_back(mk(c_LH,  32'h1002, 32'h0,        32'h80FF_1234, 0, 4'hF, 1'b0, 32'h0,        32'hFFFF_80FF, 1'b0, 1'b0, 1, 1'b0));
      vecs.push_back(mk(c_LHU, 32'h1000, 32'h0,        32'h80FF_9234, 0, 4'hF, 1'b0, 32'h0,        32'h0000_9234, 1'b0, 1'b0, 1, 1'b0));
      vecs.push_back(mk(c_LH,  32'h1000, 32'h0,        32'h80FF_9234, 1, 4'hF, 1'b0, 32'h0,        32'hFFFF_9234, 1'b0, 1'b0, 2, 1'b0));
      vecs.push_back(mk(c_LB,  32'h1000, 32'h0,        32'h0000_007F, 0, 4'hF, 1'b0, 32'h0,        32'h0000_007F, 1'b0, 1'b0, 1, 1'b0));
      vecs.push_back(mk(c_LW,  32'h1004, 32'h0,        32'hDEAD_BEEF, 3, 4'hF, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 4, 1'b0));
      vecs.push_back(mk(c_SB,  32'h2001, 32'h1234_5678, 32'h0,        0, 4'h2, 1'b1, 32'h7878_7878, 32'h0,        1'b0, 1'b0, 1, 1'b0));
      vecs.push_back(mk(c_SB,  32'h2003, 32'h0000_00AB, 32'h0,        1, 4'h8, 1'b1, 32'hABAB_ABAB, 32'h0,        1'b0, 1'b0, 2, 1'b0));
      vecs.push_back(mk(c_SW,  32'h0010, 32'hCAFE_F00D, 32'h0,        0, 4'hF, 1'b1, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0, 1, 1'b0));
      vecs.push_back(mk(c_SH,  32'h2000, 32'h1234_ABCD, 32'h0,        0, 4'h3, 1'b1, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0, 1, 1'b0));
      vecs.push_back(mk(c_SW,  32'h2002, 32'h0,        32'h0,         0, 4'h0, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1, 0, 1'b0));
      vecs.push_back(mk(c_LH,  32'h2001, 32'h0,        32'h0,         0, 4'h0, 1'b0, 32'h0,        32'h0,         1'b1, 1'b0, 0, 1'b0));
      vecs.push_back(mk(c_SH,  32'h2003, 32'h0,        32'h0,         0, 4'h0, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1, 0, 1'b0));
      vecs.push_back(mk(c_ADD, 32'h0001, 32'h0,        32'h0,         0, 4'h0, 1'b0, 32'h0,        32'h0,         1'b0, 1'b0, 0, 1'b0));
      vecs.push_back(mk(c_LWL, 32'h0000, 32'h0,        32'h0,         0, 4'h0, 1'b0, 32'h0,        32'h0,         1'b0, 1'b0, 0, 1'b0));

      reset = 1'b1;
      bus.addr_M = 32'h0; bus.wdata_M = 32'h0; bus.mem_rdata = 32'h0;
      nop();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst mem_req", bus.mem_req, 0);
      chk("rst stall", bus.stall, 0);
      chk("rst ld_valid", bus.ld_valid, 0);
      chk("rst bus_err", bus.bus_err, 0);
      chk("rst ld_data", bus.ld_data, 32'h0);
      chk("rst mem_be", bus.mem_be, 4'h0);
      chk("rst mem_addr", bus.mem_addr, 32'h0);
      @(posedge clk); #1;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Reset during the second BUSY cycle of a slow lbu.
      bus.IR_M = {c_LBU, 26'h0}; bus.addr_M = 32'h51; bus.mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstbusy req1", bus.mem_req, 1);
      @(posedge clk); #1;
      reset = 1'b1; nop();
      @(posedge clk); #1;
      reset = 1'b0; bus.mem_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("rstbusy req c%0d", c), bus.mem_req, 0);
         chk($sformatf("rstbusy stall c%0d", c), bus.stall, 0);
         chk($sformatf("rstbusy ld_valid c%0d", c), bus.ld_valid, 0);
         @(posedge clk); #1;
      end
      nop();

      // Reset and mem_ready in the same cycle: reset wins, earlier ld_data cleared.
      vecs[9].delay = 0; vecs[9].x_busy = 1;
      run_vec(100, vecs[9]);
      bus.IR_M = {c_LW, 26'h0}; bus.addr_M = 32'h60; bus.mem_rdata = 32'h55AA_55AA;
      @(posedge clk); #1;
      reset = 1'b1; bus.mem_ready = 1'b1; bus.IR_M = {c_ADD, 26'h0};
      @(posedge clk); #1;
      reset = 1'b0; bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("rstprio req", bus.mem_req, 0);
      chk("rstprio ld_valid", bus.ld_valid, 0);
      chk("rstprio ld_data", bus.ld_data, 32'h0);
      chk("rstprio mem_be", bus.mem_be, 4'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstprio ld_valid2", bus.ld_valid, 0);
      @(posedge clk); #1;

      // sw then lw through a pipeline that only advances when stall is low.
      ops[0] = {c_SW, 26'h0}; ops[1] = {c_LW, 26'h0}; ops[2] = {c_ADD, 26'h0};
      e_req   = 7'b0100100;
      e_stall = 7'b1101100;
      e_lv    = 7'b0000010;
      idx = 0;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1122_3344; bus.wdata_M = 32'hA5A5_0001;
      for (int c = 0; c < 7; c++) begin
         bus.IR_M = ops[idx];
         bus.addr_M = (idx == 0) ? 32'h10 : 32'h14;
         @(negedge clk);
         chk($sformatf("b2b req c%0d", c), bus.mem_req, e_req[c]);
         chk($sformatf("b2b stall c%0d", c), bus.stall, e_stall[c]);
         chk($sformatf("b2b ld_valid c%0d", c), bus.ld_valid, e_lv[c]);
         if (c == 1) begin
            chk("b2b sw we", bus.mem_we, 1);
            chk("b2b sw addr", bus.mem_addr, 32'h10);
         end
         if (c == 4) begin
            chk("b2b lw we", bus.mem_we, 0);
            chk("b2b lw addr", bus.mem_addr, 32'h14);
         end
         if (c == 5) chk("b2b lw data", bus.ld_data, 32'h1122_3344);
         stl = bus.stall;
         @(posedge clk); #1;
         if (!stl && idx < 2) idx++;
      end
      nop();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
